// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// stage and the data stage of a pipelined CPU.
//
// One access is in flight at a time. A grant in IDLE latches the winning
// request, BUSY runs LAT cycles (enable strobe on the first, read capture on
// the last), and DONE issues a one-cycle completion pulse to the owner.
// When both stages wait in IDLE, the one that was not served last wins.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   if_rd, if_addr        fetch read request (held until if_done) and address
//   d_rd, d_wr            data read / write request (held until d_done)
//   d_addr, d_wdata       data address and write data
//   createdump            dump request from the halt logic
//   mem_data_out          read data returned by the memory
//   if_data, d_data       last word read for each stage
//   if_stall, d_stall     stage must hold
//   if_done, d_done       one-cycle completion pulses
//   mem_enable, mem_wr    memory access strobe and write select
//   mem_addr, mem_data_in memory address and write data
//   mem_createdump        dump strobe to memory
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rd,
  input  logic [15:0] if_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        createdump,
  input  logic [15:0] mem_data_out,
  output logic [15:0] if_data,
  output logic        if_stall,
  output logic        if_done,
  output logic [15:0] d_data,
  output logic        d_stall,
  output logic        d_done,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_createdump
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam logic [2:0] LAT_C = 3'(LAT);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        owner;
  logic        last_owner;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_wr;

  logic        d_req;
  logic        any_req;
  logic        grant;

  assign d_req   = d_rd | d_wr;
  assign any_req = if_rd | d_req;

  // Round-robin pick between the two requesters; a lone requester always wins.
  always_comb begin
    grant = FETCH;
    if (if_rd && d_req) begin
      grant = (last_owner == DATA) ? FETCH : DATA;
    end else if (d_req) begin
      grant = DATA;
    end
  end

  // Access sequencer. last_owner comes out of reset as FETCH so the data
  // stage gets the first turn when both stages are waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      owner      <= FETCH;
      last_owner <= FETCH;
      lat_addr   <= 16'h0000;
      lat_wdata  <= 16'h0000;
      lat_wr     <= 1'b0;
      if_data    <= 16'h0000;
      d_data     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= BUSY;
            cnt       <= LAT_C;
            owner     <= grant;
            lat_addr  <= (grant == DATA) ? d_addr : if_addr;
            lat_wdata <= d_wdata;
            // A simultaneous read and write request is served as a read.
            lat_wr    <= (grant == DATA) && d_wr && !d_rd;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (!lat_wr) begin
              if (owner == DATA) begin
                d_data <= mem_data_out;
              end else begin
                if_data <= mem_data_out;
              end
            end
            state <= DONE;
          end
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory side is quiet outside BUSY; the strobe fires on the first BUSY cycle.
  always_comb begin
    mem_enable  = (state == BUSY) && (cnt == LAT_C);
    mem_wr      = (state == BUSY) && lat_wr;
    mem_addr    = (state == BUSY) ? lat_addr : 16'h0000;
    mem_data_in = (state == BUSY) ? lat_wdata : 16'h0000;
  end

  // Completion pulses and stalls toward the pipeline stages.
  always_comb begin
    if_done        = (state == DONE) && (owner == FETCH);
    d_done         = (state == DONE) && (owner == DATA);
    if_stall       = if_rd && !if_done;
    d_stall        = d_req && !d_done;
    mem_createdump = createdump && (state == IDLE) && !any_req;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (LAT=4 instance plus a
// LAT=1 instance). A transaction-level model tracks the age of the access in
// flight and predicts every output each cycle; a latency-accurate memory
// model only presents read data LAT-1 cycles after the enable strobe.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst, if_rd, d_rd, d_wr, createdump;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic [15:0] mem_data_out, if_data, d_data, mem_addr, mem_data_in;
  logic        if_stall, if_done, d_stall, d_done, mem_enable, mem_wr, mem_createdump;

  logic [15:0] mem_data_out1, if_data1, d_data1, mem_addr1, mem_data_in1;
  logic        if_stall1, if_done1, d_stall1, d_done1, mem_enable1, mem_wr1, mem_createdump1;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .if_rd(if_rd), .if_addr(if_addr), .d_rd(d_rd), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .createdump(createdump), .mem_data_out(mem_data_out),
    .if_data(if_data), .if_stall(if_stall), .if_done(if_done), .d_data(d_data),
    .d_stall(d_stall), .d_done(d_done), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_createdump(mem_createdump)
  );

  mem_arbiter #(.LAT(1)) dut1 (
    .clk(clk), .rst(rst), .if_rd(if_rd), .if_addr(if_addr), .d_rd(d_rd), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .createdump(createdump), .mem_data_out(mem_data_out1),
    .if_data(if_data1), .if_stall(if_stall1), .if_done(if_done1), .d_data(d_data1),
    .d_stall(d_stall1), .d_done(d_done1), .mem_enable(mem_enable1), .mem_wr(mem_wr1),
    .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_createdump(mem_createdump1)
  );

  // Memory contents before anything is written.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {~a[7:0], a[7:0]};
  endfunction

  // Latency-accurate memory for the LAT=4 instance.
  logic [15:0] bm_data [256];
  logic        bm_wrote[256];
  logic        mem_clr = 1'b1;
  logic [15:0] rd_word = 16'h0000;
  int          rd_cycle = -1;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) bm_wrote[i] <= 1'b0;
    end else if (mem_enable) begin
      if (mem_wr) begin
        bm_data[mem_addr[7:0]]  <= mem_data_in;
        bm_wrote[mem_addr[7:0]] <= 1'b1;
      end else begin
        rd_word  <= bm_wrote[mem_addr[7:0]] ? bm_data[mem_addr[7:0]] : init_val(mem_addr);
        rd_cycle <= cyc + LAT - 1;
      end
    end
  end

  assign mem_data_out  = (cyc == rd_cycle) ? rd_word : 16'hDEAD;
  assign mem_data_out1 = mem_addr1 ^ 16'h5A5A;

  // Reference model state.
  logic        m_active, m_owner_data, m_wr, m_last;
  int          m_age;
  logic [15:0] m_addr, m_wdata, m_if_data, m_d_data;
  logic [15:0] ref_mem  [256];
  logic        ref_wrote[256];

  int   n_total = 0;
  int   n_bad   = 0;
  logic checking = 1'b0;

  logic        s_en, s_if_done, s_d_done, s_wr, s_if_stall, s_d_stall, s_dump;
  logic [15:0] s_addr, s_din, s_if_data, s_d_data;
  logic        a_en[16], a_ifdone[16], a_ddone[16], a_wr[16], a_ifstall[16], b_en[16], b_ddone[16];
  logic [15:0] a_addr[16], a_din[16], a_ifdata[16], a_ddata[16], b_ddata[16];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ir, input logic [15:0] ia,
                               input logic dr, input logic dw, input logic [15:0] da,
                               input logic [15:0] dwd, input logic cd);
    rst = r; if_rd = ir; if_addr = ia; d_rd = dr; d_wr = dw;
    d_addr = da; d_wdata = dwd; createdump = cd;
  endtask

  task automatic checkOutput();
    logic busy, done;
    busy = m_active && (m_age >= 1) && (m_age <= LAT);
    done = m_active && (m_age == LAT + 1);
    check16("mem_enable", {15'd0, mem_enable}, {15'd0, m_active && (m_age == 1)});
    check16("mem_wr", {15'd0, mem_wr}, {15'd0, busy && m_wr});
    check16("mem_addr", mem_addr, busy ? m_addr : 16'h0000);
    if (busy && m_wr) check16("mem_data_in", mem_data_in, m_wdata);
    check16("if_done", {15'd0, if_done}, {15'd0, done && !m_owner_data});
    check16("d_done", {15'd0, d_done}, {15'd0, done && m_owner_data});
    check16("if_stall", {15'd0, if_stall}, {15'd0, if_rd && !(done && !m_owner_data)});
    check16("d_stall", {15'd0, d_stall}, {15'd0, (d_rd || d_wr) && !(done && m_owner_data)});
    check16("mem_createdump", {15'd0, mem_createdump},
            {15'd0, createdump && !m_active && !(if_rd || d_rd || d_wr)});
    check16("if_data", if_data, m_if_data);
    check16("d_data", d_data, m_d_data);
  endtask

  // Advances the model across one rising edge using the inputs of the cycle.
  task automatic modelAdvance();
    logic [15:0] rv;
    if (m_active && (m_age == 1) && m_wr) begin
      ref_mem[m_addr[7:0]]   = m_wdata;
      ref_wrote[m_addr[7:0]] = 1'b1;
    end
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_last = 1'b0; m_if_data = 16'h0000; m_d_data = 16'h0000;
    end else if (!m_active) begin
      if (if_rd || d_rd || d_wr) begin
        if (if_rd && (d_rd || d_wr)) m_owner_data = !m_last;
        else m_owner_data = !if_rd;
        m_addr   = m_owner_data ? d_addr : if_addr;
        m_wdata  = d_wdata;
        m_wr     = m_owner_data && d_wr && !d_rd;
        m_active = 1'b1;
        m_age    = 1;
      end
    end else begin
      if ((m_age == LAT) && !m_wr) begin
        rv = ref_wrote[m_addr[7:0]] ? ref_mem[m_addr[7:0]] : init_val(m_addr);
        if (m_owner_data) m_d_data = rv; else m_if_data = rv;
      end
      if (m_age == LAT + 1) begin
        m_active = 1'b0;
        m_last   = m_owner_data;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic runCycle(input logic r, input logic ir, input logic [15:0] ia,
                          input logic dr, input logic dw, input logic [15:0] da,
                          input logic [15:0] dwd, input logic cd);
    @(negedge clk);
    applyStimulus(r, ir, ia, dr, dw, da, dwd, cd);
    #1;
    if (checking) checkOutput();
    s_en = mem_enable; s_if_done = if_done; s_d_done = d_done; s_wr = mem_wr;
    s_if_stall = if_stall; s_d_stall = d_stall; s_dump = mem_createdump;
    s_addr = mem_addr; s_din = mem_data_in; s_if_data = if_data; s_d_data = d_data;
    @(posedge clk);
    modelAdvance();
  endtask

  task automatic resetCycle();
    runCycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // One directed sequence; cycle 0 is the first cycle after the reset cycle.
  task automatic runReq(input int ncyc, input int rst_at, input logic [15:0] ia, input int hold_if,
                        input logic dr, input logic dw, input logic [15:0] da,
                        input logic [15:0] dwd, input int hold_d);
    for (int k = 0; k < ncyc; k++) begin
      runCycle(k == rst_at, k <= hold_if, ia, (k <= hold_d) && dr, (k <= hold_d) && dw, da, dwd, 1'b0);
      a_en[k] = s_en; a_ifdone[k] = s_if_done; a_ddone[k] = s_d_done; a_wr[k] = s_wr;
      a_ifstall[k] = s_if_stall; a_addr[k] = s_addr; a_din[k] = s_din;
      a_ifdata[k] = s_if_data; a_ddata[k] = s_d_data;
      b_en[k] = mem_enable1; b_ddone[k] = d_done1; b_ddata[k] = d_data1;
    end
  endtask

  typedef struct {
    logic ir, dr, dw, cd;
    logic e_is, e_ds, e_dump;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   early;
    logic ri, dq, qrd, qwr;
    logic [15:0] ra, rda, rwd;

    for (int i = 0; i < 256; i++) ref_wrote[i] = 1'b0;
    m_active = 1'b0; m_age = 0; m_last = 1'b0; m_owner_data = 1'b0; m_wr = 1'b0;
    m_addr = 16'h0; m_wdata = 16'h0; m_if_data = 16'h0; m_d_data = 16'h0;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    resetCycle();
    resetCycle();
    @(negedge clk);
    mem_clr = 1'b0;
    checking = 1'b1;

    // Idle-state combinational behaviour, applied while reset holds the FSM in IDLE.
    vecs[0] = '{ir:1'b0, dr:1'b0, dw:1'b0, cd:1'b1, e_is:1'b0, e_ds:1'b0, e_dump:1'b1};
    vecs[1] = '{ir:1'b1, dr:1'b0, dw:1'b0, cd:1'b1, e_is:1'b1, e_ds:1'b0, e_dump:1'b0};
    vecs[2] = '{ir:1'b0, dr:1'b1, dw:1'b0, cd:1'b0, e_is:1'b0, e_ds:1'b1, e_dump:1'b0};
    vecs[3] = '{ir:1'b0, dr:1'b0, dw:1'b1, cd:1'b1, e_is:1'b0, e_ds:1'b1, e_dump:1'b0};
    vecs[4] = '{ir:1'b1, dr:1'b1, dw:1'b1, cd:1'b0, e_is:1'b1, e_ds:1'b1, e_dump:1'b0};
    vecs[5] = '{ir:1'b0, dr:1'b0, dw:1'b0, cd:1'b0, e_is:1'b0, e_ds:1'b0, e_dump:1'b0};
    for (int i = 0; i < 6; i++) begin
      runCycle(1'b1, vecs[i].ir, 16'h0, vecs[i].dr, vecs[i].dw, 16'h0, 16'h0, vecs[i].cd);
      check16("vec_if_stall", {15'd0, s_if_stall}, {15'd0, vecs[i].e_is});
      check16("vec_d_stall", {15'd0, s_d_stall}, {15'd0, vecs[i].e_ds});
      check16("vec_dump", {15'd0, s_dump}, {15'd0, vecs[i].e_dump});
    end

    // Write to 0x0020, then check reset state and the write timing.
    resetCycle();
    runReq(7, -1, 16'h0, -1, 1'b0, 1'b1, 16'h0020, 16'h1234, 5);
    check16("rst_if_data", a_ifdata[0], 16'h0000);
    check16("rst_d_data", a_ddata[0], 16'h0000);
    check16("rst_mem_enable", {15'd0, a_en[0]}, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      check16("wr_mem_wr", {15'd0, a_wr[k]}, 16'h0001);
      check16("wr_mem_addr", a_addr[k], 16'h0020);
      check16("wr_mem_data_in", a_din[k], 16'h1234);
    end
    check16("wr_d_done_c4", {15'd0, a_ddone[4]}, 16'h0000);
    check16("wr_d_done_c5", {15'd0, a_ddone[5]}, 16'h0001);
    check16("wr_d_data_kept", a_ddata[6], 16'h0000);

    // Place 0xABCD at 0x0010, then fetch it.
    resetCycle();
    runReq(7, -1, 16'h0, -1, 1'b0, 1'b1, 16'h0010, 16'hABCD, 5);
    resetCycle();
    runReq(7, -1, 16'h0010, 5, 1'b0, 1'b0, 16'h0, 16'h0, -1);
    for (int k = 0; k < 7; k++) begin
      check16("rd_mem_enable", {15'd0, a_en[k]}, {15'd0, k == 1});
      check16("rd_if_done", {15'd0, a_ifdone[k]}, {15'd0, k == 5});
      check16("rd_if_stall", {15'd0, a_ifstall[k]}, {15'd0, k <= 4});
    end
    check16("rd_if_data", a_ifdata[6], 16'hABCD);

    // Both requesters pending from reset: data first, then fetch.
    resetCycle();
    runReq(13, -1, 16'h0010, 11, 1'b1, 1'b0, 16'h0020, 16'h0, 5);
    check16("rr_first_addr", a_addr[1], 16'h0020);
    check16("rr_d_done_c5", {15'd0, a_ddone[5]}, 16'h0001);
    check16("rr_d_data", a_ddata[6], 16'h1234);
    check16("rr_fetch_enable_c7", {15'd0, a_en[7]}, 16'h0001);
    check16("rr_second_addr", a_addr[7], 16'h0010);
    check16("rr_if_done_c10", {15'd0, a_ifdone[10]}, 16'h0000);
    check16("rr_if_done_c11", {15'd0, a_ifdone[11]}, 16'h0001);
    check16("rr_if_data", a_ifdata[12], 16'hABCD);

    // Read and write together is served as a read.
    resetCycle();
    runReq(7, -1, 16'h0, -1, 1'b1, 1'b1, 16'h0020, 16'hFFFF, 5);
    early = 0;
    for (int k = 0; k < 7; k++) if (a_wr[k]) early++;
    check16("rw_mem_wr_cycles", 16'(early), 16'h0000);
    check16("rw_d_done_c5", {15'd0, a_ddone[5]}, 16'h0001);
    check16("rw_d_data", a_ddata[6], 16'h1234);

    // Reset in the second BUSY cycle aborts; the held fetch is granted again.
    resetCycle();
    runReq(10, 2, 16'h0010, 9, 1'b0, 1'b0, 16'h0, 16'h0, -1);
    early = 0;
    for (int k = 0; k < 8; k++) if (a_ifdone[k]) early++;
    check16("abort_no_done", 16'(early), 16'h0000);
    check16("abort_idle_c3", {15'd0, a_en[3]}, 16'h0000);
    check16("abort_regrant_c4", {15'd0, a_en[4]}, 16'h0001);
    check16("abort_if_done_c8", {15'd0, a_ifdone[8]}, 16'h0001);

    // Single-cycle latency instance.
    resetCycle();
    runReq(4, -1, 16'h0, -1, 1'b1, 1'b0, 16'h0033, 16'h0, 2);
    check16("lat1_enable_c1", {15'd0, b_en[1]}, 16'h0001);
    check16("lat1_d_done_c1", {15'd0, b_ddone[1]}, 16'h0000);
    check16("lat1_d_done_c2", {15'd0, b_ddone[2]}, 16'h0001);
    check16("lat1_d_data", b_ddata[2], 16'h5A69);

    // Randomized traffic checked against the model every cycle.
    resetCycle();
    ri = 1'b0; dq = 1'b0; qrd = 1'b1; qwr = 1'b0;
    ra = 16'h0; rda = 16'h0; rwd = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      if (!ri && ($urandom_range(0, 2) == 0)) ri = 1'b1;
      if (!dq && ($urandom_range(0, 2) == 0)) begin
        dq = 1'b1;
        case ($urandom_range(0, 2))
          0: begin qrd = 1'b1; qwr = 1'b0; end
          1: begin qrd = 1'b0; qwr = 1'b1; end
          default: begin qrd = 1'b1; qwr = 1'b1; end
        endcase
      end
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rda = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rwd = 16'($urandom);
      runCycle($urandom_range(0, 149) == 0, ri, ra, dq && qrd, dq && qwr, rda, rwd,
               $urandom_range(0, 3) == 0);
      if (s_if_done || ($urandom_range(0, 59) == 0)) ri = 1'b0;
      if (s_d_done || ($urandom_range(0, 59) == 0)) dq = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
